// File: rtl/demap_pkg.sv
// demap_pkg: shared types and helpers for the payload demapper scheduler
// Contents: modulation encodings, scheduler state encoding, default frame
// length and bits_per_sym(), which maps a modulation to its soft bits per symbol.
package demap_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_RSVD  = 2'd3
    } mod_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int FRAME_LEN_DEF = 2400;

    function automatic logic [2:0] bits_per_sym(input logic [1:0] mod);
        return mod == MOD_16QAM ? 3'd4 : mod == MOD_QPSK ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/demap_slot_gen.sv
// demap_slot_gen: turns FIFO read strobes into runs of soft-bit slots
// Ports: clk, rst (async, active-high); flush squashes everything in flight;
//   rd_en  - read strobe issued to the FIFO
//   m      - bits per symbol (1, 2 or 4)
//   slot_vld/bit_idx - slot valid, soft-bit index counting m-1 down to 0
//   idle   - no read, delayed read or slot left in flight
//   ready  - a read issued this cycle keeps reads at least m cycles apart
module demap_slot_gen #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       rd_en,
    input  logic [2:0] m,
    output logic       slot_vld,
    output logic [1:0] bit_idx,
    output logic       idle,
    output logic       ready
);

    // tap[k] is rd_en delayed by k cycles; a run launches from tap[RD_LAT-1]
    // so the registered slot_vld rises exactly RD_LAT cycles after rd_en.
    logic [RD_LAT:1] dly;
    logic [RD_LAT:0] tap;
    logic [1:0]      gap;

    assign tap   = {dly, rd_en};
    assign idle  = !rd_en && dly == '0 && !slot_vld;
    // gap holds cycles still to wait; a read in the current cycle only allows
    // another one straight away when a symbol is a single bit.
    assign ready = rd_en ? m == 3'd1 : gap <= 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly      <= '0;
            gap      <= 2'd0;
            slot_vld <= 1'b0;
            bit_idx  <= 2'd0;
        end else if (flush) begin
            dly      <= '0;
            gap      <= 2'd0;
            slot_vld <= 1'b0;
            bit_idx  <= 2'd0;
        end else begin
            dly <= tap[RD_LAT-1:0];
            gap <= rd_en ? 2'(m - 3'd1) : (gap != 2'd0 ? gap - 2'd1 : gap);
            if (tap[RD_LAT-1]) begin
                slot_vld <= 1'b1;
                bit_idx  <= 2'(m - 3'd1);
            end else if (slot_vld && bit_idx != 2'd0) begin
                bit_idx <= bit_idx - 2'd1;
            end else begin
                slot_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demap_sched.sv
// demap_sched: frame scheduler gating equaliser samples into the demapper FIFOs
// Ports: clk, rst (async, active-high); start/abort frame control; mod_type;
//   in_vld, fifo_full, fifo_empty from equaliser and FIFO;
//   wr_en (combinational), rd_en (registered), slot_vld/bit_idx soft-bit slots;
//   busy, frame_done, cfg_err pulses and sticky ovf_err.
// Build option DEMAP_SCHED_STATS_EN adds stat_frames and stat_drops counters.
module demap_sched
    import demap_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = 12,
    parameter int RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mod_type,
    input  logic             in_vld,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             wr_en,
    output logic             rd_en,
    output logic             slot_vld,
    output logic [1:0]       bit_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err,
    output logic             ovf_err
`ifdef DEMAP_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_frames,
    output logic [CNT_W-1:0] stat_drops
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic [1:0]       mod_q;
    logic [CNT_W-1:0] wr_cnt, acc_cnt, rd_cnt;
    logic [2:0]       m;
    logic             drop, reading, pending, slot_idle, slot_ready;

    assign m       = bits_per_sym(mod_q);
    assign busy    = state != S_IDLE;
    assign wr_en   = state == S_FILL && in_vld && !fifo_full;
    assign drop    = state == S_FILL && in_vld && fifo_full;
    assign reading = state == S_FILL || state == S_DRAIN;
    // a read strobe already high this cycle counts as consumed
    assign pending = rd_cnt + CNT_W'(rd_en) < acc_cnt;

    demap_slot_gen #(.RD_LAT(RD_LAT)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort),
        .rd_en    (rd_en),
        .m        (m),
        .slot_vld (slot_vld),
        .bit_idx  (bit_idx),
        .idle     (slot_idle),
        .ready    (slot_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mod_q      <= 2'd0;
            wr_cnt     <= '0;
            acc_cnt    <= '0;
            rd_cnt     <= '0;
            rd_en      <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            rd_en      <= !abort && reading && slot_ready && !fifo_empty && pending;
            if (rd_en) rd_cnt <= rd_cnt + CNT_W'(1);
            if (wr_en) acc_cnt <= acc_cnt + CNT_W'(1);
            if (drop) ovf_err <= 1'b1;
            if (abort) begin
                state   <= S_IDLE;
                wr_cnt  <= '0;
                acc_cnt <= '0;
                rd_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        if (mod_type == MOD_RSVD) begin
                            cfg_err <= 1'b1;
                        end else begin
                            mod_q   <= mod_type;
                            wr_cnt  <= '0;
                            acc_cnt <= '0;
                            rd_cnt  <= '0;
                            ovf_err <= 1'b0;
                            state   <= S_FILL;
                        end
                    end
                    S_FILL: if (in_vld) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                        if (wr_cnt == LAST) state <= S_DRAIN;
                    end
                    // dropped samples never reach acc_cnt, so this cannot stall
                    S_DRAIN: if (rd_cnt == acc_cnt && slot_idle) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef DEMAP_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames <= 16'd0;
            stat_drops  <= '0;
        end else begin
            if (frame_done) stat_frames <= stat_frames + 16'd1;
            if (state == S_IDLE && start && !abort && mod_type != MOD_RSVD) stat_drops <= '0;
            else if (drop) stat_drops <= stat_drops + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demap_sched.sv
// tb_demap_sched: self-checking bench for demap_sched with an ideal FIFO model
module tb_demap_sched;

    localparam int FL = 8;
    localparam int RL = 2;

    typedef struct {
        int       mod;
        bit [7:0] fmask;
        int       gap;
        bit       bstart;
        int       extra;
        int       exp_rd;
        bit       exp_ovf;
        bit       b2b;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, abort, in_vld, fifo_full, fifo_empty;
    logic [1:0] mod_type;
    logic wr_en, rd_en, slot_vld, busy, frame_done, cfg_err, ovf_err;
    logic [1:0] bit_idx;
`ifdef DEMAP_SCHED_STATS_EN
    logic [15:0] stat_frames;
    logic [11:0] stat_drops;
`endif

    int checks = 0, errors = 0, cyc_n = 0, occ = 0, done_n = 0, cfg_n = 0, wr_n = 0;
    bit exp_fill = 1'b0;
    int rd_t[$];
    int slot_t[$];
    logic [1:0] slot_b[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    demap_sched #(.FRAME_LEN(FL), .CNT_W(12), .RD_LAT(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mod_type   (mod_type),
        .in_vld     (in_vld),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .slot_vld   (slot_vld),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .ovf_err    (ovf_err)
`ifdef DEMAP_SCHED_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_drops (stat_drops)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one clock: present inputs, observe at negedge, advance the FIFO model
    task automatic cyc();
        logic w, r;
        fifo_empty = occ == 0;
        @(negedge clk);
        chk("wr_en", wr_en, exp_fill && in_vld && !fifo_full);
        if (rd_en) rd_t.push_back(cyc_n);
        if (slot_vld) begin
            slot_t.push_back(cyc_n);
            slot_b.push_back(bit_idx);
        end
        if (frame_done) done_n++;
        if (cfg_err) cfg_n++;
        if (wr_en) wr_n++;
        w = wr_en;
        r = rd_en;
        @(posedge clk);
        occ = occ + int'(w) - int'(r);
        cyc_n++;
        #1;
    endtask

    task automatic clear_log();
        rd_t.delete();
        slot_t.delete();
        slot_b.delete();
        done_n = 0;
        wr_n = 0;
    endtask

    task automatic frame(input vec_t v);
        int m, s, i, bad;
        m = 1 << v.mod;
        clear_log();
        s = cyc_n;
        start = 1'b1;
        mod_type = 2'(v.mod);
        cyc();
        exp_fill = 1'b1;
        i = 0;
        while (i < FL) begin
            in_vld = 1'($urandom_range(0, 99) >= v.gap);
            fifo_full = in_vld && v.fmask[i];
            start = v.bstart && i == 2 && in_vld;
            mod_type = start ? 2'((v.mod + 1) % 3) : 2'(v.mod);
            cyc();
            if (in_vld) i++;
            if (i == FL) exp_fill = 1'b0;
        end
        start = 1'b0;
        fifo_full = 1'b0;
        in_vld = 1'b1;
        repeat (v.extra) cyc();
        in_vld = 1'b0;
        for (int k = 0; k < 400 && done_n == 0; k++) cyc();
        repeat (3) cyc();
        chk("reads", rd_t.size(), v.exp_rd);
        chk("writes", wr_n, v.exp_rd);
        chk("slots", slot_b.size(), v.exp_rd * m);
        bad = 0;
        foreach (slot_b[k])
            if (k / m >= rd_t.size() || slot_b[k] != 2'(m - 1 - k % m) ||
                slot_t[k] != rd_t[k / m] + RL + k % m) bad++;
        chk("slot_seq", bad, 0);
        bad = 0;
        for (int k = 1; k < rd_t.size(); k++)
            if (v.b2b ? rd_t[k] - rd_t[k-1] != m : rd_t[k] - rd_t[k-1] < m) bad++;
        chk("rd_spacing", bad, 0);
        if (v.b2b) chk("first_rd", rd_t.size() > 0 ? rd_t[0] - s : -1, 3);
        chk("frame_done", done_n, 1);
        chk("ovf_err", ovf_err, v.exp_ovf);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vec_t rv;
        tbl = '{
            '{2, 8'h00,  0, 1'b0, 2, 8, 1'b0, 1'b1},
            '{1, 8'h00,  0, 1'b0, 0, 8, 1'b0, 1'b1},
            '{0, 8'h00,  0, 1'b0, 0, 8, 1'b0, 1'b1},
            '{2, 8'h0C,  0, 1'b0, 0, 6, 1'b1, 1'b0},
            '{1, 8'h80,  0, 1'b0, 1, 7, 1'b1, 1'b0},
            '{1, 8'h00,  0, 1'b1, 0, 8, 1'b0, 1'b1},
            '{0, 8'h01, 50, 1'b0, 0, 7, 1'b1, 1'b0},
            '{2, 8'h00, 40, 1'b0, 0, 8, 1'b0, 1'b0}
        };
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mod_type = 2'd0;
        in_vld = 1'b1;
        fifo_full = 1'b0;
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_slot_vld", slot_vld, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_ovf_err", ovf_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        in_vld = 1'b0;

        start = 1'b1;
        mod_type = 2'd3;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        chk("cfg_err_pulses", cfg_n, 1);
        chk("cfg_busy", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        mod_type = 2'd1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_wins", busy, 0);

        for (int t = 0; t < 8; t++) frame(tbl[t]);

        clear_log();
        start = 1'b1;
        mod_type = 2'd2;
        cyc();
        start = 1'b0;
        exp_fill = 1'b1;
        for (int i = 0; i < FL; i++) begin
            in_vld = 1'b1;
            fifo_full = i == 0;
            cyc();
        end
        exp_fill = 1'b0;
        in_vld = 1'b0;
        fifo_full = 1'b0;
        for (int k = 0; k < 100 && rd_t.size() < 3; k++) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_slot_vld", slot_vld, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_ovf_held", ovf_err, 1);
        n = slot_b.size();
        repeat (20) cyc();
        chk("abort_no_done", done_n, 0);
        chk("abort_reads", rd_t.size(), 3);
        chk("abort_slots_frozen", slot_b.size(), n);
        occ = 0;
        frame(tbl[0]);

        start = 1'b1;
        mod_type = 2'd2;
        cyc();
        start = 1'b0;
        exp_fill = 1'b1;
        in_vld = 1'b1;
        repeat (5) cyc();
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_slot_vld", slot_vld, 0);
        chk("midrst_bit_idx", bit_idx, 0);
        exp_fill = 1'b0;
        in_vld = 1'b0;
        occ = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        frame(tbl[0]);

        for (int r = 0; r < 12; r++) begin
            rv.mod = $urandom_range(0, 2);
            rv.fmask = 8'($urandom & $urandom & $urandom);
            rv.gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 60);
            rv.bstart = 1'b0;
            rv.extra = $urandom_range(0, 3);
            rv.exp_rd = FL - $countones(rv.fmask);
            rv.exp_ovf = rv.fmask != 0;
            rv.b2b = rv.gap == 0 && rv.fmask == 0;
            frame(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
